// File: rtl/rock_pkg.sv
// rock_pkg: state encoding, saturating level helpers and default thresholds for rock_ctrl_gen
package rock_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, HOLD = 2'd2, RAMP_DOWN = 2'd3} state_t;
  localparam int HR_THR_DEF = 120;
  localparam int CRY_THR_DEF = 80;
  localparam int HOLD_TICKS_DEF = 8;
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? max : v + 8'd1;
  endfunction
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction
endpackage

// File: rtl/rock_avg.sv
// rock_avg: single-channel moving-average window, zero-filled after reset
//   clk, reset (async active-low), tick (shift enable), sample in,
//   avg_next = average including the sample entering on this tick
module rock_avg #(
  parameter int DATA_W = 8,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg_next
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  logic [DATA_W-1:0] win [DEPTH];
  logic [SUM_W-1:0] sum, sum_next;
  assign sum_next = sum + SUM_W'(sample) - SUM_W'(win[DEPTH-1]);
  assign avg_next = DATA_W'(sum_next >> AVG_LOG2);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else if (tick) begin
      sum <= sum_next;
      win[0] <= sample;
      for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
    end
endmodule

// File: rtl/rock_ctrl_gen.sv
// rock_ctrl_gen: tick-enabled cradle rocking controller with averaged stress detection
//   clk, reset (async active-low), tick (step enable), hartslag/huilVol samples,
//   amp/freq levels, state (IDLE/RAMP_UP/HOLD/RAMP_DOWN), stress flag.
//   MANUAL_OVERRIDE_EN adds ovr/ovr_amp/ovr_freq to force levels and park the FSM in HOLD.
module rock_ctrl_gen
  import rock_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LVL_W = 3,
  parameter int AVG_LOG2 = 2,
  parameter int HR_THR = HR_THR_DEF,
  parameter int CRY_THR = CRY_THR_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF,
  parameter int FREQ_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] hartslag,
  input  logic [DATA_W-1:0] huilVol,
`ifdef MANUAL_OVERRIDE_EN
  input  logic              ovr,
  input  logic [LVL_W-1:0]  ovr_amp,
  input  logic [LVL_W-1:0]  ovr_freq,
`endif
  output logic [LVL_W-1:0]  amp,
  output logic [LVL_W-1:0]  freq,
  output logic [1:0]        state,
  output logic              stress
);
  localparam int LVL_MAX = (1 << LVL_W) - 1;
  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam int DIV_W = FREQ_DIV > 1 ? $clog2(FREQ_DIV) : 1;
  localparam logic [DATA_W-1:0] HR_T = DATA_W'(HR_THR);
  localparam logic [DATA_W-1:0] CRY_T = DATA_W'(CRY_THR);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FREQ_DIV - 1);
  state_t st, st_next;
  logic [DATA_W-1:0] hr_avg, cry_avg;
  logic [LVL_W-1:0] amp_next, freq_next, amp_up, freq_up, amp_dn, freq_dn, frc_amp, frc_freq;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [DIV_W-1:0] div, div_next;
  logic frc;
`ifdef MANUAL_OVERRIDE_EN
  assign frc = ovr;
  assign frc_amp = ovr_amp;
  assign frc_freq = ovr_freq;
`else
  assign frc = 1'b0;
  assign frc_amp = '0;
  assign frc_freq = '0;
`endif
  rock_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_hr (
    .clk(clk), .reset(reset), .tick(tick), .sample(hartslag), .avg_next(hr_avg));
  rock_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_cry (
    .clk(clk), .reset(reset), .tick(tick), .sample(huilVol), .avg_next(cry_avg));
  assign amp_up = LVL_W'(sat_inc(8'(amp), 8'(LVL_MAX)));
  assign freq_up = LVL_W'(sat_inc(8'(freq), 8'(LVL_MAX)));
  assign amp_dn = LVL_W'(sat_dec(8'(amp)));
  assign freq_dn = LVL_W'(sat_dec(8'(freq)));
  assign state = st;
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else st <= frc ? HOLD : tick ? st_next : st;
  // FSM reacts to the stress flag registered on the previous tick
  always_comb
    case (st)
      IDLE:    st_next = stress ? RAMP_UP : IDLE;
      RAMP_UP: st_next = stress ? RAMP_UP : HOLD;
      HOLD:    st_next = stress ? RAMP_UP : (cnt == CNT_W'(1)) ? RAMP_DOWN : HOLD;
      default: st_next = stress ? RAMP_UP : (amp == '0 && freq == '0) ? IDLE : RAMP_DOWN;
    endcase
  // levels only move on ticks that stay in a ramp state; transition ticks leave them alone
  always_comb begin
    amp_next = amp;
    freq_next = freq;
    cnt_next = cnt;
    div_next = div;
    if (st_next == RAMP_UP && st != RAMP_UP) div_next = '0;
    else if (st == RAMP_UP && stress) begin
      amp_next = amp_up;
      freq_next = (div == DIV_LAST) ? freq_up : freq;
      div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end else if (st == RAMP_UP) cnt_next = HOLD_LOAD;
    else if (st == HOLD) cnt_next = cnt - CNT_W'(1);
    else if (st == RAMP_DOWN && !stress) begin
      amp_next = amp_dn;
      freq_next = freq_dn;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      amp <= '0;
      freq <= '0;
      cnt <= '0;
      div <= '0;
      stress <= 1'b0;
    end else begin
      if (tick) stress <= (hr_avg > HR_T) || (cry_avg > CRY_T);
      if (frc) begin
        amp <= frc_amp;
        freq <= frc_freq;
        cnt <= HOLD_LOAD;
      end else if (tick) begin
        amp <= amp_next;
        freq <= freq_next;
        cnt <= cnt_next;
        div <= div_next;
      end
    end
endmodule

// File: tb/tb_rock_ctrl_gen.sv
// tb_rock_ctrl_gen: vector table, directed corner sequences and random stimulus against a behavioural model
module tb_rock_ctrl_gen;
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
  logic [7:0] hartslag = '0, huilVol = '0;
  logic [2:0] amp, freq;
  logic [1:0] state;
  logic stress;
`ifdef MANUAL_OVERRIDE_EN
  logic ovr = 1'b0;
  logic [2:0] ovr_amp = '0, ovr_freq = '0;
`endif
  int n_chk = 0, n_fail = 0;
  int hq[$], cq[$];
  int m_amp, m_freq, m_state, m_stress, m_ramp, m_held;

  always #5 clk = ~clk;

  rock_ctrl_gen dut (
    .clk(clk), .reset(reset), .tick(tick), .hartslag(hartslag), .huilVol(huilVol),
`ifdef MANUAL_OVERRIDE_EN
    .ovr(ovr), .ovr_amp(ovr_amp), .ovr_freq(ovr_freq),
`endif
    .amp(amp), .freq(freq), .state(state), .stress(stress));

  typedef struct {
    bit tk;
    int hr;
    int cry;
    int e_amp;
    int e_freq;
    int e_state;
    int e_stress;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qavg(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / q.size();
  endfunction

  task automatic m_reset();
    hq = {0, 0, 0, 0};
    cq = {0, 0, 0, 0};
    m_amp = 0; m_freq = 0; m_state = 0; m_stress = 0; m_ramp = 0; m_held = 0;
  endtask

  // behavioural reference: one clock edge of the controller
  task automatic m_clk(input bit tk, input int hr, input int cry, input bit ov, input int oa, input int of);
    int s = m_stress;
    if (tk) begin
      hq.push_front(hr); void'(hq.pop_back());
      cq.push_front(cry); void'(cq.pop_back());
      m_stress = (qavg(hq) > 120 || qavg(cq) > 80) ? 1 : 0;
    end
    if (ov) begin
      m_amp = oa; m_freq = of; m_state = 2; m_held = 0;
    end else if (tk) begin
      if (m_state == 0) begin
        if (s != 0) begin m_state = 1; m_ramp = 0; end
      end else if (m_state == 1) begin
        if (s == 0) begin m_state = 2; m_held = 0; end
        else begin
          m_ramp++;
          m_amp = (m_amp < 7) ? m_amp + 1 : 7;
          if (m_ramp % 2 == 0) m_freq = (m_freq < 7) ? m_freq + 1 : 7;
        end
      end else if (m_state == 2) begin
        if (s != 0) begin m_state = 1; m_ramp = 0; end
        else begin
          m_held++;
          if (m_held == 8) m_state = 3;
        end
      end else begin
        if (s != 0) begin m_state = 1; m_ramp = 0; end
        else if (m_amp == 0 && m_freq == 0) m_state = 0;
        else begin
          m_amp = (m_amp > 0) ? m_amp - 1 : 0;
          m_freq = (m_freq > 0) ? m_freq - 1 : 0;
        end
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".amp"}, int'(amp), m_amp);
    chk({tag, ".freq"}, int'(freq), m_freq);
    chk({tag, ".state"}, int'(state), m_state);
    chk({tag, ".stress"}, int'(stress), m_stress);
  endtask

  task automatic step(input string tag, input bit tk, input int hr, input int cry,
                      input bit ov = 1'b0, input int oa = 0, input int of = 0);
    tick = tk;
    hartslag = 8'(hr);
    huilVol = 8'(cry);
`ifdef MANUAL_OVERRIDE_EN
    ovr = ov;
    ovr_amp = 3'(oa);
    ovr_freq = 3'(of);
`endif
    @(posedge clk);
    m_clk(tk, hr, cry, ov, oa, of);
    #1;
    cmp_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0;
    reset = 1'b0;
    m_reset();
    #2;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int n_hold, a0;
    bit found;
    m_reset();
    tbl[0] = '{1, 200, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 200, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 200, 0, 0, 0, 0, 1};
    tbl[3] = '{1, 200, 0, 0, 0, 1, 1};
    tbl[4] = '{1, 200, 0, 1, 0, 1, 1};
    tbl[5] = '{1, 200, 0, 2, 1, 1, 1};
    tbl[6] = '{0, 0, 0, 2, 1, 1, 1};
    tbl[7] = '{1, 200, 0, 3, 1, 1, 1};
    tbl[8] = '{1, 200, 0, 4, 2, 1, 1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst.amp", int'(amp), 0);
    chk("rst.freq", int'(freq), 0);
    chk("rst.state", int'(state), 0);
    chk("rst.stress", int'(stress), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 9; i++) begin
      step("tbl", tbl[i].tk, tbl[i].hr, tbl[i].cry);
      chk($sformatf("vec%0d.amp", i), int'(amp), tbl[i].e_amp);
      chk($sformatf("vec%0d.freq", i), int'(freq), tbl[i].e_freq);
      chk($sformatf("vec%0d.state", i), int'(state), tbl[i].e_state);
      chk($sformatf("vec%0d.stress", i), int'(stress), tbl[i].e_stress);
    end
    // asynchronous reset away from any clock edge
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst.amp", int'(amp), 0);
    chk("async_rst.freq", int'(freq), 0);
    chk("async_rst.state", int'(state), 0);
    chk("async_rst.stress", int'(stress), 0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) step("hr_eq", 1'b1, 120, 80);
    chk("hr_at_thr.stress", int'(stress), 0);
    step("hr_above", 1'b1, 124, 0);
    chk("hr_above_thr.stress", int'(stress), 1);
    do_reset();
    for (int i = 0; i < 4; i++) step("cry_eq", 1'b1, 0, 80);
    chk("cry_at_thr.stress", int'(stress), 0);
    step("cry_above", 1'b1, 0, 84);
    chk("cry_above_thr.stress", int'(stress), 1);
    // saturation, hold length and decay
    do_reset();
    for (int i = 0; i < 25; i++) step("sat", 1'b1, 0, 255);
    chk("sat.amp", int'(amp), 7);
    chk("sat.freq", int'(freq), 7);
    for (int i = 0; i < 5; i++) step("sat2", 1'b1, 0, 255);
    chk("nowrap.amp", int'(amp), 7);
    chk("nowrap.freq", int'(freq), 7);
    n_hold = 0;
    for (int i = 0; i < 40; i++) begin
      step("decay", 1'b1, 0, 0);
      if (state == 2'd2) n_hold++;
    end
    chk("hold_ticks", n_hold, 8);
    chk("decay_end.state", int'(state), 0);
    chk("decay_end.amp", int'(amp), 0);
    // re-stress during HOLD
    for (int i = 0; i < 25; i++) step("sat3", 1'b1, 0, 255);
    for (int i = 0; i < 7; i++) step("to_hold", 1'b1, 0, 0);
    chk("in_hold.state", int'(state), 2);
    for (int i = 0; i < 4; i++) step("rehold", 1'b1, 0, 255);
    chk("rehold.state", int'(state), 1);
    // re-stress during RAMP_DOWN at amp=5
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("to_rd", 1'b1, 0, 0);
      if (state == 2'd3 && amp == 3'd5) found = 1'b1;
    end
    chk("reach_rd_amp5", int'(found), 1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step("re_rd", 1'b1, 0, 255);
      if (state == 2'd1) found = 1'b1;
    end
    chk("rd_restress_ramp", int'(found), 1);
    a0 = int'(amp);
    step("re_rd_up", 1'b1, 0, 255);
    chk("rd_continue.amp", int'(amp), a0 + 1);
    // tick gating with toggling inputs
    for (int i = 0; i < 100; i++) step("gate", 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    for (int i = 0; i < 6; i++) step("post_gate", 1'b1, 0, 0);
`ifdef MANUAL_OVERRIDE_EN
    do_reset();
    step("ovr", 1'b0, 0, 0, 1'b1, 3, 5);
    chk("ovr.amp", int'(amp), 3);
    chk("ovr.freq", int'(freq), 5);
    chk("ovr.state", int'(state), 2);
    n_hold = 0;
    for (int i = 0; i < 20; i++) begin
      step("ovr_rel", 1'b1, 0, 0);
      if (state == 2'd2) n_hold++;
    end
    chk("ovr_hold_ticks", n_hold, 7);
    chk("ovr_end.state", int'(state), 0);
    chk("ovr_end.freq", int'(freq), 0);
`endif
    // random phases of calm and stress
    do_reset();
    for (int p = 0; p < 40; p++) begin
      bit hi = 1'($urandom_range(0, 1));
      for (int k = 0; k < 40; k++) begin
        bit tk = ($urandom_range(0, 3) != 0);
        int hr = hi ? int'($urandom_range(90, 255)) : int'($urandom_range(0, 140));
        int cry = hi ? int'($urandom_range(60, 255)) : int'($urandom_range(0, 100));
`ifdef MANUAL_OVERRIDE_EN
        step("rnd", tk, hr, cry, $urandom_range(0, 49) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
`else
        step("rnd", tk, hr, cry);
`endif
      end
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rock_ctrl_gen.md
Name: rock_ctrl_gen

Overview:
Parametrised successor to the cradle rocking controller. It uses a single-clock, tick-enabled design, so no derived slow clock and no logic-generated clock.
- Filters heart-rate (hartslag) and cry-volume (huilVol) samples through a moving-average window.
- Drives rocking amplitude/frequency levels through a ramp/hold/decay FSM.
- Sits between the sensor front-ends and the motor driver.

Parameters:
DATA_W, 8, width of hartslag/huilVol samples
LVL_W, 3, width of amp/freq outputs; max level LVL_MAX = 2^LVL_W-1
AVG_LOG2, 2, log2 of moving-average depth (depth = 2^AVG_LOG2, 1..16 entries)
HR_THR, 8'd120, averaged heart-rate stress threshold (strictly greater-than)
CRY_THR, 8'd80, averaged cry-volume stress threshold (strictly greater-than)
HOLD_TICKS, 8, ticks to hold levels after stress clears (>=1)
FREQ_DIV, 2, ticks per freq step (amp steps every tick)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  single-cycle sample/step enable
hartslag  in  DATA_W  heart-rate sample
huilVol  in  DATA_W  cry-volume sample
amp  out  LVL_W  rocking amplitude level
freq  out  LVL_W  rocking frequency level
state  out  2  FSM state (IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3)
stress  out  1  registered stress flag from averaged values

Behaviour:
- Reset (reset=0, async assert, sync release): amp=0, freq=0, state=IDLE, stress=0, window entries=0, sums=0, counters=0.
- All state changes happen only on clk edges with tick=1. tick=0 holds everything.
- Averaging:
  - Per channel: shift register of 2^AVG_LOG2 entries plus running sum of width DATA_W+AVG_LOG2.
  - On tick: sum <= sum + new - oldest; new sample shifts in.
  - avg = sum >> AVG_LOG2. The window is zero-filled after reset, so the average ramps in over the first depth ticks.
- stress <= (avg_hr_next > HR_THR) || (avg_cry_next > CRY_THR), registered on the same tick the sample enters. Latency from sample to stress is 1 clk.
- FSM, evaluated on tick using the registered stress value (from the previous tick):
  - IDLE: amp=freq=0. stress -> RAMP_UP.
  - RAMP_UP:
    - amp increments by 1 each tick, saturating at LVL_MAX.
    - freq increments by 1 every FREQ_DIV-th tick in this state, saturating. The divider counter clears on entry.
    - !stress -> HOLD; hold counter loaded with HOLD_TICKS.
  - HOLD: levels frozen; counter decrements each tick. stress -> RAMP_UP (counter discarded). Counter reaches 1 on a tick -> RAMP_DOWN.
  - RAMP_DOWN: amp and freq each decrement by 1 per tick, floored at 0. stress -> RAMP_UP (levels continue from current values). amp==0 && freq==0 -> IDLE.
- Outputs are registers. amp/freq change 1 clk after the qualifying tick edge.
- Wrap-around is forbidden: all level arithmetic saturates at 0 and LVL_MAX.
- Reset mid-ramp returns immediately to the reset values; the window is cleared.

Optional Feature:
MANUAL_OVERRIDE_EN:
- When defined, the block adds three inputs: ovr (1), ovr_amp (LVL_W), ovr_freq (LVL_W).
- While ovr=1, amp/freq follow ovr_amp/ovr_freq registered on every clk (tick not required), and the FSM is forced to HOLD with the hold counter reloaded. Averaging continues.
- On ovr falling, normal sequencing resumes from HOLD with the overridden levels.
- When undefined, these ports do not exist and the behaviour is as above.

Decomposition:
- Package rock_pkg: state enum (IDLE/RAMP_UP/HOLD/RAMP_DOWN), the sat_inc/sat_dec level helper functions, and default threshold constants.
- One sub-module, rock_avg: a single-channel moving-average window parametrised by DATA_W/AVG_LOG2. It is instantiated twice (heart rate, cry volume).

Test Plan:
- Reset mid-operation: drive reset=0 asynchronously while amp=4 -> amp/freq/state become 0/0/IDLE immediately. After release, the first 4 ticks with hartslag=200 give avg 50,100,150,200, and stress asserts on the 3rd tick (150>120).
- Ramp to saturation: huilVol=255 held, defaults -> amp reaches 7 and stays 7. freq increments every 2nd tick in RAMP_UP, reaching 7; no wrap to 0.
- Hold then decay: after saturation, drop inputs to 0 -> stress clears once avg<=thresholds. HOLD for exactly 8 ticks, then amp/freq decrement 1 per tick to 0, then IDLE.
- Re-stress during HOLD and during RAMP_DOWN: raise huilVol=255 -> FSM returns to RAMP_UP within 1 tick of the stress assert, continuing from the current levels (e.g. amp=5 -> 6).
- Tick gating: toggle inputs with tick=0 for 100 clks -> no change in any output or the averages.
- With MANUAL_OVERRIDE_EN defined: ovr=1, ovr_amp=3, ovr_freq=5 -> outputs become 3/5 one clk later and state=HOLD. After ovr drops with no stress: 8 ticks of hold, then decay to 0.
